// File: rtl/ni_flit_sender.sv
// Hermes local-port packet injector: sends a header flit, a size flit and then
// buffered payload flits into one router input using the credit handshake.
module ni_flit_sender #(
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_valid,
  input  logic [FLIT_WIDTH-1:0] send_target,
  input  logic [FLIT_WIDTH-1:0] send_size,
  output logic                  send_ready,
  input  logic                  pl_valid,
  input  logic [FLIT_WIDTH-1:0] pl_data,
  output logic                  pl_ready,
  output logic                  clock_rx,
  output logic                  rx,
  output logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  credit_o,
  output logic                  busy,
  output logic                  pkt_sent
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t                state;
  logic [FLIT_WIDTH-1:0] tgt_r;
  logic [FLIT_WIDTH-1:0] size_r;
  logic [FLIT_WIDTH-1:0] rem_r;
  logic [FLIT_WIDTH-1:0] in_cnt;

  logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  xfer;

  assign clock_rx   = clock;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_CNT);
  assign send_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Intake runs ahead during HEADER/SIZE; full is the registered flag only.
  assign pl_ready = (state != IDLE) && !fifo_full && (in_cnt < size_r);
  assign push     = pl_valid && pl_ready;
  assign xfer     = rx && credit_o;
  assign pop      = (state == PAYLOAD) && xfer;

  always_comb begin
    rx     = 1'b0;
    data_i = '0;
    case (state)
      HEADER: begin
        rx     = 1'b1;
        data_i = tgt_r;
      end
      SIZE: begin
        rx     = 1'b1;
        data_i = size_r;
      end
      PAYLOAD: begin
        rx     = !fifo_empty;
        data_i = fifo_empty ? '0 : mem[rd_ptr];
      end
      default: begin
        rx     = 1'b0;
        data_i = '0;
      end
    endcase
  end

  // Packet sequencing: header, size, then exactly size_r payload transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      size_r   <= '0;
      rem_r    <= '0;
      in_cnt   <= '0;
      pkt_sent <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      if (push) begin
        in_cnt <= in_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (send_valid) begin
            size_r <= send_size;
            rem_r  <= send_size;
            in_cnt <= '0;
            state  <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) begin
            state <= SIZE;
          end
        end
        SIZE: begin
          if (xfer) begin
            if (size_r == '0) begin
              state    <= IDLE;
              pkt_sent <= 1'b1;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            rem_r <= rem_r - 1'b1;
            if (rem_r == FLIT_WIDTH'(1)) begin
              state    <= IDLE;
              pkt_sent <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Target word is pure data and only read while the packet is in flight.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && send_valid) begin
      tgt_r <= send_target;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= pl_data;
    end
  end

  // Pointers wrap modulo depth; occupancy distinguishes full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_flit_sender.sv
// Bench for ni_flit_sender: packet-level model compared every cycle, plus
// directed scenarios with literal wire sequences.
module tb_ni_flit_sender;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clock;
  logic         reset;
  logic         send_valid;
  logic [W-1:0] send_target;
  logic [W-1:0] send_size;
  logic         send_ready;
  logic         pl_valid;
  logic [W-1:0] pl_data;
  logic         pl_ready;
  logic         clock_rx;
  logic         rx;
  logic [W-1:0] data_i;
  logic         credit_o;
  logic         busy;
  logic         pkt_sent;

  ni_flit_sender #(.FLIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .send_valid(send_valid), .send_target(send_target), .send_size(send_size),
    .send_ready(send_ready),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .clock_rx(clock_rx), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .busy(busy), .pkt_sent(pkt_sent)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pkt_cnt = 0;
  int acc_cnt = 0;
  int plr_cnt = 0;
  logic [W-1:0] src_q[$];
  logic [W-1:0] log_q[$];
  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  logic         hold_chk = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- packet-level model ----------------
  logic         m_active = 1'b0;
  logic [W-1:0] m_hdr[$];
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] m_size = '0;
  logic [W-1:0] m_rem = '0;
  logic [W-1:0] m_in = '0;
  logic         m_pkt_sent = 1'b0;
  logic         m_xfer;
  logic         m_push;

  function automatic logic m_rx();
    return m_active && (m_hdr.size() > 0 || m_fifo.size() > 0);
  endfunction

  function automatic logic [W-1:0] m_data();
    if (m_hdr.size() > 0) return m_hdr[0];
    if (m_fifo.size() > 0) return m_fifo[0];
    return '0;
  endfunction

  function automatic logic m_plr();
    return m_active && (m_fifo.size() < DEPTH) && (m_in < m_size);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_hdr.delete();
      m_fifo.delete();
      m_size = '0;
      m_rem = '0;
      m_in = '0;
      m_pkt_sent = 1'b0;
    end else begin
      m_xfer = m_rx() && credit_o;
      m_push = pl_valid && m_plr();
      m_pkt_sent = 1'b0;
      if (!m_active) begin
        if (send_valid) begin
          m_active = 1'b1;
          m_hdr.delete();
          m_hdr.push_back(send_target);
          m_hdr.push_back(send_size);
          m_size = send_size;
          m_rem = send_size;
          m_in = '0;
        end
      end else begin
        if (m_push) begin
          m_fifo.push_back(pl_data);
          m_in++;
        end
        if (m_xfer) begin
          if (m_hdr.size() > 0) begin
            void'(m_hdr.pop_front());
            if (m_hdr.size() == 0 && m_size == '0) begin
              m_active = 1'b0;
              m_pkt_sent = 1'b1;
            end
          end else begin
            void'(m_fifo.pop_front());
            m_rem--;
            if (m_rem == '0) begin
              m_active = 1'b0;
              m_pkt_sent = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- compare + monitor (away from the active edge) ----------------
  always @(negedge clock) begin
    chkb("send_ready", send_ready, !m_active);
    chkb("busy", busy, m_active);
    chkb("rx", rx, m_rx());
    chkb("pl_ready", pl_ready, m_plr());
    chkb("pkt_sent", pkt_sent, m_pkt_sent);
    chkb("clock_rx", clock_rx, clock);
    if (m_rx()) chk("data_i", data_i, m_data());
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chkb("hold_rx", rx, 1'b1);
        chk("hold_data", data_i, hold_d);
      end
      hold_chk = rx && !credit_o;
      hold_d = data_i;
      if (rx && credit_o) begin
        log_q.push_back(data_i);
        stamp_q.push_back(cyc);
      end
      if (pkt_sent) pkt_cnt++;
      if (pl_valid && pl_ready) acc_cnt++;
      if (pl_ready) plr_cnt++;
    end
  end

  // ---------------- payload source ----------------
  always @(posedge clock) begin
    #1;
    if (src_q.size() > 0) begin
      pl_valid = 1'b1;
      pl_data = src_q[0];
      if (pl_ready) void'(src_q.pop_front());
    end else begin
      pl_valid = 1'b0;
      pl_data = '0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic clear_logs();
    log_q.delete();
    stamp_q.delete();
    exp_q.delete();
    pkt_cnt = 0;
    acc_cnt = 0;
    plr_cnt = 0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, W'(log_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) chk($sformatf("%s_flit%0d", name, i), log_q[i], exp_q[i]);
    end
  endtask

  task automatic send_req(input logic [W-1:0] t, input logic [W-1:0] s);
    logic done;
    done = 1'b0;
    send_target = t;
    send_size = s;
    send_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (send_ready) done = 1'b1;
      tick();
    end
    send_valid = 1'b0;
    if (!done) fail_now("send_req");
  endtask

  task automatic wait_idle(input int n);
    logic done;
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    if (!done) fail_now("wait_idle");
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic done;
    reset = 1'b1;
    send_valid = 1'b0;
    send_target = '0;
    send_size = '0;
    credit_o = 1'b1;
    #1;
    chkb("rst_send_ready", send_ready, 1'b1);
    chkb("rst_pl_ready", pl_ready, 1'b0);
    chkb("rst_rx", rx, 1'b0);
    chk("rst_data_i", data_i, '0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_pkt_sent", pkt_sent, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // basic packet, size 3
    clear_logs();
    src_q.push_back(32'hA1); src_q.push_back(32'hA2); src_q.push_back(32'hA3);
    send_req(32'h0011, 32'd3);
    chkb("t1_hdr_rx", rx, 1'b1);
    chk("t1_hdr_data", data_i, 32'h0011);
    wait_idle(40);
    ex(32'h0011); ex(32'h0003); ex(32'hA1); ex(32'hA2); ex(32'hA3);
    check_log("t1");
    if (stamp_q.size() == 5) chk("t1_span", W'(stamp_q[4] - stamp_q[0]), 32'd4);
    else fail_now("t1_span");
    chk("t1_pkt_sent_cnt", W'(pkt_cnt), 32'd1);
    chkb("t1_busy_after", busy, 1'b0);

    // zero-size packet with a stray payload flit offered
    clear_logs();
    src_q.delete();
    src_q.push_back(32'h0BAD);
    send_req(32'h0102, 32'd0);
    wait_idle(20);
    ex(32'h0102); ex(32'h0000);
    check_log("t2");
    if (stamp_q.size() == 2) chk("t2_span", W'(stamp_q[1] - stamp_q[0]), 32'd1);
    else fail_now("t2_span");
    chk("t2_pl_ready_cycles", W'(plr_cnt), 32'd0);
    chk("t2_stray_left", W'(src_q.size()), 32'd1);
    chk("t2_pkt_sent_cnt", W'(pkt_cnt), 32'd1);
    chkb("t2_busy_after", busy, 1'b0);

    // size 6 with credit toggling 1,0,0,1
    clear_logs();
    src_q.delete();
    for (int i = 1; i <= 6; i++) src_q.push_back(W'(32'h300 + i));
    send_req(32'h0033, 32'd6);
    for (int i = 1; i < 80 && busy; i++) begin
      credit_o = pat[i % 4];
      tick();
    end
    if (busy) fail_now("t3_finish");
    credit_o = 1'b1;
    tick();
    ex(32'h0033); ex(32'h0006);
    for (int i = 1; i <= 6; i++) ex(W'(32'h300 + i));
    check_log("t3");
    chk("t3_pkt_sent_cnt", W'(pkt_cnt), 32'd1);

    // prefetch fills the FIFO while the header is stalled
    clear_logs();
    src_q.delete();
    credit_o = 1'b0;
    for (int i = 1; i <= 6; i++) src_q.push_back(W'(32'h400 + i));
    send_req(32'h0044, 32'd6);
    repeat (8) tick();
    chk("t4_accepted", W'(acc_cnt), 32'd4);
    chkb("t4_pl_ready_full", pl_ready, 1'b0);
    chkb("t4_rx_held", rx, 1'b1);
    chk("t4_hdr_held", data_i, 32'h0044);
    credit_o = 1'b1;
    tick();
    tick();
    chkb("t4_pl_ready_at_pop", pl_ready, 1'b0);
    tick();
    chkb("t4_pl_ready_after_pop", pl_ready, 1'b1);
    wait_idle(40);
    ex(32'h0044); ex(32'h0006);
    for (int i = 1; i <= 6; i++) ex(W'(32'h400 + i));
    check_log("t4");

    // reset in the middle of the payload
    clear_logs();
    src_q.delete();
    for (int i = 1; i <= 5; i++) src_q.push_back(W'(32'h500 + i));
    send_req(32'h0055, 32'd5);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (log_q.size() >= 4) done = 1'b1;
      else tick();
    end
    if (!done) fail_now("t5_progress");
    #2;
    reset = 1'b1;
    #1;
    chkb("t5_rx_async", rx, 1'b0);
    chkb("t5_busy_async", busy, 1'b0);
    chkb("t5_send_ready_async", send_ready, 1'b1);
    chkb("t5_pl_ready_async", pl_ready, 1'b0);
    src_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
    src_q.push_back(32'hB1);
    send_req(32'h0066, 32'd1);
    wait_idle(20);
    ex(32'h0066); ex(32'h0001); ex(32'hB1);
    check_log("t5");
    chk("t5_pkt_sent_cnt", W'(pkt_cnt), 32'd1);

    // back-to-back requests with send_valid held
    clear_logs();
    src_q.delete();
    src_q.push_back(32'h601); src_q.push_back(32'h602); src_q.push_back(32'h611);
    send_target = 32'h0021;
    send_size = 32'd2;
    send_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (send_ready) done = 1'b1;
      tick();
    end
    if (!done) fail_now("t6_first_req");
    send_target = 32'h0022;
    send_size = 32'd1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (send_ready) done = 1'b1;
      tick();
    end
    if (!done) fail_now("t6_second_req");
    send_valid = 1'b0;
    wait_idle(40);
    ex(32'h0021); ex(32'h0002); ex(32'h601); ex(32'h602);
    ex(32'h0022); ex(32'h0001); ex(32'h611);
    check_log("t6");
    if (stamp_q.size() == 7) chk("t6_gap", W'(stamp_q[4] - stamp_q[3]), 32'd2);
    else fail_now("t6_gap");
    chk("t6_pkt_sent_cnt", W'(pkt_cnt), 32'd2);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
